// File: rtl/dmem_port_arbiter.sv
// rtl/dmem_port_arbiter.sv - round-robin data memory port arbiter with bounded burst hold
module dmem_port_arbiter #(
    parameter int ADDR_W    = 8,
    parameter int DATA_W    = 32,
    parameter int MAX_BURST = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_gnt,
    output logic              m0_rvalid,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m1_gnt,
    output logic              m1_rvalid,
    output logic [DATA_W-1:0] rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int               CNT_W     = $clog2(MAX_BURST + 1);
    localparam logic [CNT_W-1:0] BURST_LIM = CNT_W'(MAX_BURST);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    logic             owner_q, owner_d;
    logic             owner_valid_q, owner_valid_d;
    logic [CNT_W-1:0] burst_cnt_q, burst_cnt_d;
    logic             rr_ptr_q, rr_ptr_d;
    logic             rd_pend0_q, rd_pend0_d;
    logic             rd_pend1_q, rd_pend1_d;

    logic gnt0, gnt1, gnt_any, pick;

    // Same-cycle grant: a single requester wins outright; under contention the
    // owner keeps the port until its burst budget is spent, else the other side wins.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        pick = rr_ptr_q;
        if (!rst) begin
            if (m0_req && !m1_req) begin
                gnt0 = 1'b1;
            end else if (m1_req && !m0_req) begin
                gnt1 = 1'b1;
            end else if (m0_req && m1_req) begin
                if (owner_valid_q && (burst_cnt_q < BURST_LIM)) begin
                    pick = owner_q;
                end else if (owner_valid_q) begin
                    pick = ~owner_q;
                end else begin
                    pick = rr_ptr_q;
                end
                gnt0 = ~pick;
                gnt1 = pick;
            end
        end
    end

    assign gnt_any = gnt0 | gnt1;
    assign m0_gnt  = gnt0;
    assign m1_gnt  = gnt1;

    // Memory port mux; idle cycles drive zeros so the bus is quiet.
    always_comb begin
        mem_en    = gnt_any;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (gnt0) begin
            mem_we    = m0_we;
            mem_addr  = m0_addr;
            mem_wdata = m0_wdata;
        end else if (gnt1) begin
            mem_we    = m1_we;
            mem_addr  = m1_addr;
            mem_wdata = m1_wdata;
        end
    end

    // Next-state for ownership, burst counting and read tracking.
    always_comb begin
        owner_d       = owner_q;
        owner_valid_d = 1'b0;
        burst_cnt_d   = '0;
        rr_ptr_d      = rr_ptr_q;
        if (gnt_any) begin
            owner_d       = gnt1;
            owner_valid_d = 1'b1;
            rr_ptr_d      = ~gnt1;
            if (!owner_valid_q || (owner_q != gnt1)) begin
                burst_cnt_d = CNT_ONE;
            end else if (burst_cnt_q >= BURST_LIM) begin
                burst_cnt_d = BURST_LIM;
            end else begin
                burst_cnt_d = burst_cnt_q + CNT_ONE;
            end
        end
        rd_pend0_d = gnt0 & ~m0_we;
        rd_pend1_d = gnt1 & ~m1_we;
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            owner_q       <= 1'b0;
            owner_valid_q <= 1'b0;
            burst_cnt_q   <= '0;
            rr_ptr_q      <= 1'b0;
            rd_pend0_q    <= 1'b0;
            rd_pend1_q    <= 1'b0;
        end else begin
            owner_q       <= owner_d;
            owner_valid_q <= owner_valid_d;
            burst_cnt_q   <= burst_cnt_d;
            rr_ptr_q      <= rr_ptr_d;
            rd_pend0_q    <= rd_pend0_d;
            rd_pend1_q    <= rd_pend1_d;
        end
    end

    // A reset arriving right after a read grant suppresses that read's return.
    assign m0_rvalid = rd_pend0_q & ~rst;
    assign m1_rvalid = rd_pend1_q & ~rst;
    assign rdata     = mem_rdata;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// tb/tb_dmem_port_arbiter.sv - scoreboard bench for dmem_port_arbiter
module tb_dmem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        m0_req, m0_we, m1_req, m1_we;
    logic [7:0]  m0_addr, m1_addr;
    logic [31:0] m0_wdata, m1_wdata;
    logic        m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
    logic [31:0] rdata;
    logic        mem_en, mem_we;
    logic [7:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    int errs = 0;
    int chks = 0;

    typedef struct {
        bit          port;
        logic        we;
        logic [7:0]  addr;
        logic [31:0] data;
    } gexp_t;

    typedef struct {
        bit          port;
        logic [31:0] data;
    } rexp_t;

    gexp_t gq[$];
    rexp_t rq[$];
    gexp_t mg;
    rexp_t mr;

    logic [31:0] mem [256];

    dmem_port_arbiter #(.ADDR_W(8), .DATA_W(32), .MAX_BURST(4)) dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid),
        .rdata(rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Single-port memory model: write in grant cycle, read data one cycle later.
    always @(posedge clk) begin
        if (rst) begin
            mem[5] <= 32'h0000_00AB;
        end else if (mem_en) begin
            if (mem_we) mem[mem_addr] <= mem_wdata;
            else        mem_rdata     <= mem[mem_addr];
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        chks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_g(input bit port, input logic we, input logic [7:0] addr, input logic [31:0] data);
        gexp_t e;
        e.port = port; e.we = we; e.addr = addr; e.data = data;
        gq.push_back(e);
    endtask

    task automatic push_r(input bit port, input logic [31:0] data);
        rexp_t e;
        e.port = port; e.data = data;
        rq.push_back(e);
    endtask

    task automatic drive(input logic r0, input logic w0, input logic [7:0] a0, input logic [31:0] d0,
                         input logic r1, input logic w1, input logic [7:0] a1, input logic [31:0] d1);
        m0_req = r0; m0_we = w0; m0_addr = a0; m0_wdata = d0;
        m1_req = r1; m1_we = w1; m1_addr = a1; m1_wdata = d1;
    endtask

    task automatic idle();
        drive(0, 0, 8'd0, 32'd0, 0, 0, 8'd0, 32'd0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet(input string tag);
        @(negedge clk);
        chk({tag, "_gnt"}, {30'd0, m1_gnt, m0_gnt}, 32'd0);
        chk({tag, "_mem_en"}, {31'd0, mem_en}, 32'd0);
        chk({tag, "_mem_we"}, {31'd0, mem_we}, 32'd0);
    endtask

    // Monitor: every grant or read return must match the head of its queue.
    always @(negedge clk) begin
        if (m0_gnt || m1_gnt) begin
            if (gq.size() == 0) begin
                chk("unexpected_gnt", {30'd0, m1_gnt, m0_gnt}, 32'd0);
            end else begin
                mg = gq.pop_front();
                chk("gnt_vec", {30'd0, m1_gnt, m0_gnt}, mg.port ? 32'd2 : 32'd1);
                chk("mem_en", {31'd0, mem_en}, 32'd1);
                chk("mem_we", {31'd0, mem_we}, {31'd0, mg.we});
                chk("mem_addr", {24'd0, mem_addr}, {24'd0, mg.addr});
                chk("mem_wdata", mem_wdata, mg.data);
            end
        end
        if (m0_rvalid || m1_rvalid) begin
            if (rq.size() == 0) begin
                chk("unexpected_rvalid", {30'd0, m1_rvalid, m0_rvalid}, 32'd0);
            end else begin
                mr = rq.pop_front();
                chk("rvalid_vec", {30'd0, m1_rvalid, m0_rvalid}, mr.port ? 32'd2 : 32'd1);
                chk("rdata", rdata, mr.data);
            end
        end
    end

    bit [8:0] burst_exp;
    bit [2:0] alt_exp;

    initial begin
        rst = 1'b1;
        drive(1, 1, 8'd1, 32'h11, 1, 1, 8'd2, 32'h22);
        tick();
        repeat (2) begin
            quiet("reset");
            tick();
        end

        // First contended grant after reset goes to m0, then m1 alone.
        rst = 1'b0;
        push_g(0, 1, 8'd1, 32'h11);
        tick();
        drive(0, 0, 8'd0, 32'd0, 1, 1, 8'd2, 32'h22);
        push_g(1, 1, 8'd2, 32'h22);
        tick();

        // Alternating single-cycle contention after idle: m0, m1, m0.
        alt_exp = 3'b010;
        for (int i = 0; i < 3; i++) begin
            idle();
            quiet("idle");
            tick();
            drive(1, 1, 8'd3, 32'h33, 1, 1, 8'd4, 32'h44);
            push_g(alt_exp[i], 1, alt_exp[i] ? 8'd4 : 8'd3, alt_exp[i] ? 32'h44 : 32'h33);
            tick();
        end

        // Continuous contention: last grant was m0 so m1 starts; 4-grant bursts.
        idle();
        tick();
        burst_exp = 9'b1_0000_1111;
        drive(1, 1, 8'd10, 32'h100, 1, 1, 8'd11, 32'h200);
        for (int i = 0; i < 9; i++) begin
            push_g(burst_exp[i], 1, burst_exp[i] ? 8'd11 : 8'd10, burst_exp[i] ? 32'h200 : 32'h100);
            tick();
        end

        // Single read of preloaded word.
        idle();
        tick();
        drive(1, 0, 8'd5, 32'd0, 0, 0, 8'd0, 32'd0);
        push_g(0, 0, 8'd5, 32'd0);
        push_r(0, 32'h0000_00AB);
        tick();
        idle();
        tick();

        // m1 write, then m0 reads it back next cycle.
        drive(0, 0, 8'd0, 32'd0, 1, 1, 8'd31, 32'hDEAD_BEEF);
        push_g(1, 1, 8'd31, 32'hDEAD_BEEF);
        tick();
        drive(1, 0, 8'd31, 32'd0, 0, 0, 8'd0, 32'd0);
        push_g(0, 0, 8'd31, 32'd0);
        push_r(0, 32'hDEAD_BEEF);
        tick();
        idle();
        tick();

        // Reset right after a read grant: no read return, state back to reset.
        drive(1, 0, 8'd5, 32'd0, 0, 0, 8'd0, 32'd0);
        push_g(0, 0, 8'd5, 32'd0);
        tick();
        rst = 1'b1;
        drive(1, 1, 8'd6, 32'h66, 1, 1, 8'd7, 32'h77);
        @(negedge clk);
        chk("rst_m0_rvalid", {31'd0, m0_rvalid}, 32'd0);
        chk("rst_m1_rvalid", {31'd0, m1_rvalid}, 32'd0);
        chk("rst_gnt", {30'd0, m1_gnt, m0_gnt}, 32'd0);
        tick();
        quiet("reset2");
        tick();
        rst = 1'b0;
        push_g(0, 1, 8'd6, 32'h66);
        tick();
        idle();
        repeat (3) tick();

        chk("gnt_queue_empty", gq.size(), 32'd0);
        chk("rd_queue_empty", rq.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errs, chks);
        $finish;
    end

endmodule
